// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - LEGv8 memory stage: LDUR/STUR on a req/ack data port, stall, branch resolve, fault
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   valid_M, memRead_M, memWrite_M   EX/MEM slot status and access type (both set = store)
//   branch_M, zero_M, PCBranch_M     branch resolution inputs
//   aluResult_M, writeData_M         effective address and store data
//   PCSrc_M, PCBranch_out            branch decision and target to fetch
//   stall_M                          freeze IF..MEM while an access is in flight
//   readData_M, fault_M              load result and one-cycle fault pulse (DONE cycle only)
//   dm_req, dm_we, dm_addr, dm_wdata registered data-memory request
//   dm_ack, dm_rdata, dm_err         data-memory response
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter bit CHECK_ALIGN    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_M,
    input  logic        memRead_M,
    input  logic        memWrite_M,
    input  logic        branch_M,
    input  logic        zero_M,
    input  logic [63:0] aluResult_M,
    input  logic [63:0] writeData_M,
    input  logic [63:0] PCBranch_M,
    output logic        PCSrc_M,
    output logic [63:0] PCBranch_out,
    output logic        stall_M,
    output logic [63:0] readData_M,
    output logic        fault_M,
    output logic        dm_req,
    output logic        dm_we,
    output logic [63:0] dm_addr,
    output logic [63:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [63:0] dm_rdata,
    input  logic        dm_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [63:0]      addr_q, addr_d;
    logic [63:0]      wdata_q, wdata_d;
    logic [63:0]      rdata_q, rdata_d;
    logic             fault_q, fault_d;

    logic acc;
    logic misaligned;

    assign acc        = valid_M & (memRead_M | memWrite_M);
    assign misaligned = CHECK_ALIGN & (aluResult_M[2:0] != 3'b000);

    // Branch resolution is purely combinational so fetch can redirect even while stalled.
    assign PCSrc_M      = valid_M & branch_M & zero_M;
    assign PCBranch_out = PCBranch_M;

    // Stall starts in the launch cycle itself, before dm_req is visible.
    assign stall_M    = (state_q == ACCESS) | ((state_q == IDLE) & acc);
    assign readData_M = (state_q == DONE) ? rdata_q : 64'd0;
    assign fault_M    = (state_q == DONE) & fault_q;

    assign dm_req   = req_q;
    assign dm_we    = we_q;
    assign dm_addr  = addr_q;
    assign dm_wdata = wdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    if (misaligned) begin
                        fault_d = 1'b1;
                        rdata_d = 64'd0;
                        state_d = DONE;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = memWrite_M;
                        addr_d  = aluResult_M;
                        wdata_d = writeData_M;
                        cnt_d   = '0;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (dm_ack) begin
                    req_d   = 1'b0;
                    rdata_d = we_q ? 64'd0 : dm_rdata;
                    fault_d = dm_err;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    rdata_d = 64'd0;
                    fault_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // Slot advances at the end of this cycle; the next instruction is seen in IDLE.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            rdata_q <= 64'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_M, memRead_M, memWrite_M, branch_M, zero_M;
    logic [63:0] aluResult_M, writeData_M, PCBranch_M;
    logic        PCSrc_M;
    logic [63:0] PCBranch_out;
    logic        stall_M;
    logic [63:0] readData_M;
    logic        fault_M;
    logic        dm_req, dm_we;
    logic [63:0] dm_addr, dm_wdata;
    logic        dm_ack;
    logic [63:0] dm_rdata;
    logic        dm_err;

    int n_cmp = 0;
    int n_bad = 0;

    mem_stage_lsu #(.TIMEOUT_CYCLES(TMO), .CHECK_ALIGN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .valid_M(valid_M), .memRead_M(memRead_M), .memWrite_M(memWrite_M),
        .branch_M(branch_M), .zero_M(zero_M),
        .aluResult_M(aluResult_M), .writeData_M(writeData_M), .PCBranch_M(PCBranch_M),
        .PCSrc_M(PCSrc_M), .PCBranch_out(PCBranch_out), .stall_M(stall_M),
        .readData_M(readData_M), .fault_M(fault_M),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_err(dm_err)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h want 0x%h", name, act, exp);
        end
    endfunction

    // Transaction-level model: an outstanding request with a wait count,
    // and a pending report (data/fault) shown for one cycle afterwards.
    bit          armed = 1'b0;
    bit          outstanding = 1'b0;
    int          waited = 0;
    bit          report = 1'b0;
    logic [63:0] rep_data = '0;
    bit          rep_fault = 1'b0;
    bit          req_we = 1'b0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    bit          m_acc;

    always @(negedge clk) begin
        m_acc = valid_M & (memRead_M | memWrite_M);
        if (armed) begin
            chk("m_pcsrc", PCSrc_M, valid_M & branch_M & zero_M);
            chk("m_pcbranch", PCBranch_out, PCBranch_M);
            chk("m_stall", stall_M, outstanding | (!report & m_acc));
            chk("m_req", dm_req, outstanding);
            chk("m_rdata", readData_M, report ? rep_data : 64'd0);
            chk("m_fault", fault_M, report & rep_fault);
            if (outstanding) begin
                chk("m_we", dm_we, req_we);
                chk("m_addr", dm_addr, req_addr);
                chk("m_wdata", dm_wdata, req_wdata);
            end
        end
        if (reset) begin
            armed = 1'b1;
            outstanding = 1'b0;
            report = 1'b0;
        end else if (report) begin
            report = 1'b0;
        end else if (outstanding) begin
            waited++;
            if (dm_ack) begin
                outstanding = 1'b0;
                report = 1'b1;
                rep_data = req_we ? 64'd0 : dm_rdata;
                rep_fault = dm_err;
            end else if (waited == TMO) begin
                outstanding = 1'b0;
                report = 1'b1;
                rep_data = 64'd0;
                rep_fault = 1'b1;
            end
        end else if (m_acc) begin
            if (aluResult_M[2:0] != 3'b000) begin
                report = 1'b1;
                rep_data = 64'd0;
                rep_fault = 1'b1;
            end else begin
                outstanding = 1'b1;
                waited = 0;
                req_we = memWrite_M;
                req_addr = aluResult_M;
                req_wdata = writeData_M;
            end
        end
    end

    task automatic idle_inputs();
        valid_M = 0; memRead_M = 0; memWrite_M = 0; branch_M = 0; zero_M = 0;
        aluResult_M = '0; writeData_M = '0; PCBranch_M = '0;
        dm_ack = 0; dm_rdata = '0; dm_err = 0;
    endtask

    // Presents one memory instruction; ack_at = ACCESS cycle (1-based) carrying dm_ack, 0 = never.
    task automatic run_mem(input logic [63:0] a, input bit st, input logic [63:0] wd,
                           input int ack_at, input logic [63:0] rd, input bit err,
                           output int n_stall, output int n_req, output bit f, output logic [63:0] r);
        n_stall = 0; n_req = 0; f = 0; r = '0;
        valid_M = 1; memRead_M = !st; memWrite_M = st; aluResult_M = a; writeData_M = wd;
        for (int k = 0; k < 64; k++) begin
            dm_ack = (ack_at > 0) && (k == ack_at);
            dm_rdata = rd;
            dm_err = err;
            @(negedge clk);
            if (dm_req) begin
                n_req++;
                chk("req_we", dm_we, st);
                chk("req_wdata", dm_wdata, wd);
                chk("req_addr", dm_addr, a);
            end
            if (stall_M && branch_M) begin
                chk("br_pcsrc_in_stall", PCSrc_M, 1);
                chk("br_target_in_stall", PCBranch_out, 64'h40);
            end
            if (stall_M) n_stall++;
            else begin
                f = fault_M;
                r = readData_M;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    int          ns, nr;
    bit          ff;
    logic [63:0] rr;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "time limit");
    end

    initial begin
        idle_inputs();
        reset = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_stall", stall_M, 0);
        chk("rst_fault", fault_M, 0);
        chk("rst_rdata", readData_M, 0);
        chk("rst_req", dm_req, 0);
        chk("rst_we", dm_we, 0);
        chk("rst_addr", dm_addr, 0);
        chk("rst_wdata", dm_wdata, 0);
        @(posedge clk); #1;
        reset = 0;

        // ALU-only instruction
        valid_M = 1; aluResult_M = 64'h2A;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("alu_stall", stall_M, 0);
            chk("alu_req", dm_req, 0);
            chk("alu_rdata", readData_M, 0);
            @(posedge clk); #1;
        end
        idle_inputs();

        // Load, ack on first ACCESS cycle, with a taken branch visible during the stall
        branch_M = 1; zero_M = 1; PCBranch_M = 64'h40;
        run_mem(64'h100, 0, 64'h0, 1, 64'hDEADBEEF_00000001, 0, ns, nr, ff, rr);
        chk("ld_stall_cycles", ns, 2);
        chk("ld_req_cycles", nr, 1);
        chk("ld_fault", ff, 0);
        chk("ld_data", rr, 64'hDEADBEEF_00000001);

        // Store, ack on 5th ACCESS cycle; returned read data must not leak
        run_mem(64'h208, 1, 64'h55, 5, 64'h1234, 0, ns, nr, ff, rr);
        chk("st_stall_cycles", ns, 6);
        chk("st_req_cycles", nr, 5);
        chk("st_fault", ff, 0);
        chk("st_data", rr, 0);

        // Misaligned load
        run_mem(64'h103, 0, 64'h0, 1, 64'h99, 0, ns, nr, ff, rr);
        chk("mis_stall_cycles", ns, 1);
        chk("mis_req_cycles", nr, 0);
        chk("mis_fault", ff, 1);
        chk("mis_data", rr, 0);

        // Bus error on second ACCESS cycle
        run_mem(64'h300, 0, 64'h0, 2, 64'hABCD, 1, ns, nr, ff, rr);
        chk("err_stall_cycles", ns, 3);
        chk("err_fault", ff, 1);
        chk("err_data", rr, 64'hABCD);

        // Timeout with a late ack afterwards
        run_mem(64'h500, 0, 64'h0, 0, 64'h77, 0, ns, nr, ff, rr);
        chk("tmo_req_cycles", nr, TMO);
        chk("tmo_stall_cycles", ns, TMO + 1);
        chk("tmo_fault", ff, 1);
        chk("tmo_data", rr, 0);
        @(posedge clk); #1;
        dm_ack = 1; dm_rdata = 64'h77;
        @(negedge clk);
        chk("late_ack_stall", stall_M, 0);
        chk("late_ack_req", dm_req, 0);
        @(posedge clk); #1;
        dm_ack = 0;
        @(negedge clk);
        chk("late_ack_fault", fault_M, 0);
        chk("late_ack_rdata", readData_M, 0);
        @(posedge clk); #1;

        // Reset during the 3rd ACCESS cycle
        valid_M = 1; memRead_M = 1; aluResult_M = 64'h400;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1; valid_M = 0; memRead_M = 0;
        @(negedge clk);
        chk("rstmid_req_before", dm_req, 1);
        @(posedge clk); #1;
        reset = 0; dm_ack = 1; dm_rdata = 64'h88;
        @(negedge clk);
        chk("rstmid_req", dm_req, 0);
        chk("rstmid_stall", stall_M, 0);
        chk("rstmid_rdata", readData_M, 0);
        @(posedge clk); #1;
        dm_ack = 0;
        @(negedge clk);
        chk("rstmid_fault", fault_M, 0);
        chk("rstmid_rdata2", readData_M, 0);
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory stage of the 64-bit LEGv8 pipeline; consumes the execute-stage results held in the EX/MEM register (ALU result as address, store data, branch target, zero flag).
- Performs LDUR/STUR accesses on a request/acknowledge data-memory port with variable latency.
- Stalls the pipeline while an access is outstanding, resolves the branch decision (PCSrc), and flags misaligned or failed accesses.

Parameters:
- TIMEOUT_CYCLES, 16, maximum ACCESS-state cycles waited for dm_ack before declaring a fault (must be ≥1).
- CHECK_ALIGN, 1, when 1 an address with addr[2:0]≠0 faults without issuing a request.

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- valid_M  input  1  EX/MEM slot holds a live instruction
- memRead_M  input  1  instruction is a load
- memWrite_M  input  1  instruction is a store
- branch_M  input  1  instruction is CBZ/B-class branch
- zero_M  input  1  zero flag from execute
- aluResult_M  input  64  effective address (or ALU result for non-memory instr)
- writeData_M  input  64  store data
- PCBranch_M  input  64  branch target from execute
- PCSrc_M  output  1  take branch
- PCBranch_out  output  64  target forwarded to fetch
- stall_M  output  1  freeze IF..MEM, bubble into WB
- readData_M  output  64  load data to MEM/WB
- fault_M  output  1  one-cycle pulse: misaligned, timeout, or dm_err
- dm_req  output  1  memory request (registered)
- dm_we  output  1  1=write, 0=read (registered)
- dm_addr  output  64  registered address
- dm_wdata  output  64  registered store data
- dm_ack  input  1  request complete (one cycle)
- dm_rdata  input  64  read data, valid with dm_ack
- dm_err  input  1  bus error, valid with dm_ack

Behaviour:
- Reset (synchronous, active-high): state=IDLE, timeout counter=0, dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, read-data register=0, fault register=0; therefore stall_M=0, fault_M=0, readData_M=0.
- PCSrc_M = valid_M & branch_M & zero_M, combinational, independent of FSM and stall.
- PCBranch_out = PCBranch_M.
- acc = valid_M & (memRead_M | memWrite_M). If both memRead_M and memWrite_M are set, treat as a store.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - !acc: stall_M=0, readData_M=0, latency 0.
  - acc & misaligned (CHECK_ALIGN=1): no request issued; go to DONE with fault latched.
  - acc & aligned: stall_M=1 combinationally; at the edge, dm_req<=1, dm_we<=memWrite_M, dm_addr<=aluResult_M, dm_wdata<=writeData_M, counter<=0; go to ACCESS.
- ACCESS:
  - stall_M=1; dm_req and payload held stable until ack; counter increments each cycle.
  - dm_ack: dm_req<=0, capture dm_rdata (loads only; stores capture 0), fault<=dm_err, go to DONE.
  - No ack and counter==TIMEOUT_CYCLES-1: dm_req<=0, fault<=1, data<=0, go to DONE. A late ack arriving afterwards is ignored.
- DONE (exactly 1 cycle):
  - stall_M=0; readData_M=captured data; fault_M=latched fault.
  - The pipeline advances at the end of this cycle; next state IDLE. The new instruction is evaluated in IDLE on the following cycle, so no double issue.
- Best-case load/store latency: 3 cycles (IDLE launch, ACCESS with ack, DONE) → stall asserted 2 cycles.
- dm_ack while in IDLE or DONE: ignored.
- Reset mid-ACCESS: dm_req drops at that edge and the state returns to IDLE; an outstanding ack is ignored.
- fault_M never asserts for non-memory instructions or when valid_M=0.

Test Plan:
- ALU-only instr (valid_M=1, memRead/Write=0, aluResult_M=0x2A) → stall_M=0 every cycle, dm_req never 1, readData_M=0.
- Load at 0x100, dm_ack on first ACCESS cycle with dm_rdata=0xDEADBEEF_00000001 → stall_M high 2 cycles; dm_addr=0x100, dm_we=0; DONE cycle readData_M=0xDEADBEEF_00000001, fault_M=0.
- Store 0x55 to 0x208, ack after 5 ACCESS cycles → dm_we=1 and dm_wdata=0x55 stable through all 5 cycles; stall_M high 6 cycles; fault_M=0.
- Load at 0x103 (misaligned) → no dm_req; cycle 1 stall_M=1; cycle 2 fault_M=1, readData_M=0; next cycle IDLE.
- Load with no ack, TIMEOUT_CYCLES=16 → dm_req high exactly 16 cycles then 0; DONE fault_M=1; ack injected 2 cycles later has no effect.
- Reset asserted on 3rd ACCESS cycle → next cycle dm_req=0, stall_M=0, state IDLE.
- Branch with zero_M=1, PCBranch_M=0x40, during a load stall → PCSrc_M=1 and PCBranch_out=0x40 in the same cycle.
